// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and opcode legality.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_ASR = 4'b1010;

    localparam int FLG_Z  = 3;
    localparam int FLG_C  = 2;
    localparam int FLG_NF = 1;
    localparam int FLG_V  = 0;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_SHL, OP_SHR, OP_ASR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active request at or above prio.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  prio_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            gnt_vld_o
);

    logic [IDW-1:0] idx_s;

    // Scan upward from prio, wrapping modulo NREQ, and keep the first hit.
    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        idx_s     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s = IDW'((int'(prio_i) + i) % NREQ);
            if (!gnt_vld_o && req_i[idx_s]) begin
                gnt_o[idx_s] = 1'b1;
                gnt_id_o     = idx_s;
                gnt_vld_o    = 1'b1;
            end else begin
                gnt_vld_o = gnt_vld_o;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters with round-robin issue and a latency-matched tag pipe.
// Define ALU_ARB_OPCHECK_EN to turn illegal opcodes into bubbles answered with rsp_err.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N    = 16,
    parameter int NREQ = 2,
    parameter int LAT  = 1,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [3:0]        alu_op,
    input  logic [N-1:0]      alu_result,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err
);

    logic [NREQ-1:0] req_eff_s;
    logic [IDW-1:0]  gnt_id_s;
    logic            hs_s;
    logic [N-1:0]    sel_a_s, sel_b_s;
    logic [3:0]      sel_op_s;
    logic            illegal_s;
    logic            load_s;
    logic [IDW-1:0]  prio_q, prio_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [LAT:0]    vld_q, err_q;
    logic [IDW-1:0]  id_q [LAT+1];

    // Grants are suppressed while issue is disabled or reset is held.
    assign req_eff_s = req_valid & {NREQ{en & rst}};

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req_i     (req_eff_s),
        .prio_i    (prio_q),
        .gnt_o     (req_ready),
        .gnt_id_o  (gnt_id_s),
        .gnt_vld_o (hs_s)
    );

    assign sel_a_s  = req_a[int'(gnt_id_s)*N +: N];
    assign sel_b_s  = req_b[int'(gnt_id_s)*N +: N];
    assign sel_op_s = req_op[int'(gnt_id_s)*4 +: 4];

`ifdef ALU_ARB_OPCHECK_EN
    assign illegal_s = hs_s & ~op_legal(sel_op_s);
`else
    assign illegal_s = 1'b0;
`endif
    assign load_s = hs_s & ~illegal_s;

    // Next-state for issue registers and round-robin pointer.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        prio_d = prio_q;
        if (load_s) begin
            a_d  = sel_a_s;
            b_d  = sel_b_s;
            op_d = sel_op_s;
        end else begin
            op_d = op_q;
        end
        if (hs_s) begin
            prio_d = (gnt_id_s == IDW'(NREQ-1)) ? '0 : gnt_id_s + IDW'(1);
        end else begin
            prio_d = prio_q;
        end
    end

    // Issue registers, pointer and tag pipe; the tag pipe never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 4'b0000;
            prio_q <= '0;
            vld_q  <= '0;
            err_q  <= '0;
            for (int k = 0; k <= LAT; k++) id_q[k] <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            prio_q <= prio_d;
            vld_q  <= {vld_q[LAT-1:0], hs_s};
            err_q  <= {err_q[LAT-1:0], illegal_s};
            id_q[0] <= gnt_id_s;
            for (int k = 1; k <= LAT; k++) id_q[k] <= id_q[k-1];
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign rsp_valid = vld_q[LAT];
    assign rsp_id    = id_q[LAT];
    assign rsp_err   = vld_q[LAT] & err_q[LAT];

    // Response payload: ALU data for good ops, zeros for errored ops and idle cycles.
    always_comb begin
        rsp_result = '0;
        rsp_flags  = 4'b0000;
        if (vld_q[LAT] && !err_q[LAT]) begin
            rsp_result = alu_result;
            rsp_flags  = alu_flags;
        end else begin
            rsp_result = '0;
            rsp_flags  = 4'b0000;
        end
    end

endmodule
